equiv_sweep_checker: RTL and testbench
======================================

// Module: equiv_sweep_checker
// PURPOSE
//   Synthesizable exhaustive equivalence checker for two implementations of one
//   truth table (e.g. DDNF vs DKNF forms). Sweeps every IN_W-bit input vector,
//   drives it to both implementations, compares their OUT_W-bit responses after a
//   settle delay, counts mismatches and captures the first failing vector.
// PARAMETERS
//   IN_W    8  input vector width; the sweep covers 0 .. 2^IN_W-1
//   OUT_W   5  output width of each implementation under comparison
//   SETTLE  1  cycles o_x is held before the response is sampled (>=1)
// PORTS
//   clk            in   1        single clock; all state changes on posedge
//   rst            in   1        synchronous, active-high reset
//   i_start        in   1        start a sweep (sampled in IDLE or DONE only)
//   i_stop_on_err  in   1        1: end sweep at first mismatch; 0: run full sweep
//   i_y_a          in   OUT_W    response of implementation A to o_x
//   i_y_b          in   OUT_W    response of implementation B to o_x
//   o_x            out  IN_W     current input vector fed to both implementations
//   o_busy         out  1        sweep in progress
//   o_done         out  1        sweep finished; held until next start or reset
//   o_error        out  1        at least one mismatch seen in this sweep
//   o_err_cnt      out  IN_W+1   number of mismatching vectors (max 2^IN_W)
//   o_first_x      out  IN_W     first mismatching vector
//   o_first_a      out  OUT_W    i_y_a captured at first mismatch
//   o_first_b      out  OUT_W    i_y_b captured at first mismatch
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0. rst wins over every other input.
//   - FSM IDLE/DRIVE/CHECK/DONE. IDLE|DONE + i_start -> DRIVE: o_x<=0, clear
//     o_error, o_err_cnt, o_first_*, o_done<=0, o_busy<=1 (next cycle).
//   - i_stop_on_err latched at start; changes during a sweep are ignored.
//   - DRIVE: o_x stable for SETTLE cycles (settle counter), then -> CHECK.
//   - CHECK (one cycle): compare i_y_a vs i_y_b. Mismatch: o_err_cnt+1, o_error<=1;
//     if first mismatch, load o_first_x<=o_x, o_first_a/b<=i_y_a/b.
//     If (mismatch && stop latched) or o_x==all-ones -> DONE; else o_x<=o_x+1, DRIVE.
//   - Each vector costs SETTLE+1 cycles; full clean sweep = 2^IN_W*(SETTLE+1)
//     cycles of o_busy. o_x never wraps: all-ones is the last vector checked.
//   - DONE: o_busy=0, o_done=1; o_x, o_err_cnt, o_first_* hold their values.
//   - i_start while busy is ignored. o_err_cnt cannot overflow (IN_W+1 bits).
//   - rst mid-sweep: immediate return to IDLE, all results cleared.
// TESTING
//   1 IN_W=8,SETTLE=1, y_b=y_a always, start -> busy 512 cycles, done=1,
//     error=0, err_cnt=0, o_x=8'hFF.
//   2 y_b differs only at x=8'h5A, stop=1 -> done, err_cnt=1, first_x=8'h5A,
//     o_x=8'h5A, first_a/b equal injected values.
//   3 mismatches at x=8'h00,8'h80,8'hFF, stop=0 -> err_cnt=3, first_x=8'h00,
//     o_x=8'hFF, sweep takes full 512 cycles.
//   4 i_start pulsed at cycle 100 of a sweep, stop toggled mid-sweep -> no
//     restart, behaviour unchanged vs scenario 1/3.
//   5 rst asserted at cycle 200 -> next cycle all outputs 0, state IDLE; new
//     start then runs a complete clean sweep.
//   6 start again from DONE after scenario 3 -> counters cleared, o_done drops
//     for the new sweep, results reproduce scenario 3.

Source files
------------

// File: rtl/equiv_sweep_checker.sv
// Exhaustive equivalence sweep: walks every input vector, compares two
// implementation responses after a settle delay, counts and records mismatches.
module equiv_sweep_checker #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop_on_err,
    input  logic [OUT_W-1:0] i_y_a,
    input  logic [OUT_W-1:0] i_y_b,
    output logic [IN_W-1:0]  o_x,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [IN_W:0]    o_err_cnt,
    output logic [IN_W-1:0]  o_first_x,
    output logic [OUT_W-1:0] o_first_a,
    output logic [OUT_W-1:0] o_first_b
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [IN_W-1:0]  X_ZERO      = {IN_W{1'b0}};
    localparam logic [IN_W-1:0]  X_ONE       = IN_W'(1);
    localparam logic [IN_W-1:0]  X_LAST      = {IN_W{1'b1}};
    localparam logic [IN_W:0]    ERR_ZERO    = {(IN_W+1){1'b0}};
    localparam logic [IN_W:0]    ERR_ONE     = (IN_W+1)'(1);
    localparam logic [OUT_W-1:0] Y_ZERO      = {OUT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic responses_differ(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b);
        return (a != b);
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic             stop_r;
    logic [IN_W-1:0]  x_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;
    logic [IN_W:0]    err_cnt_r;
    logic [IN_W-1:0]  first_x_r;
    logic [OUT_W-1:0] first_a_r;
    logic [OUT_W-1:0] first_b_r;

    logic             mismatch_s;
    logic             sweep_end_s;

    // Compare decision for the vector currently held on o_x
    always_comb begin
        mismatch_s  = 1'b0;
        sweep_end_s = 1'b0;
        if (state_r == ST_CHECK) begin
            mismatch_s  = responses_differ(i_y_a, i_y_b);
            sweep_end_s = (mismatch_s && stop_r) || (x_r == X_LAST);
        end else begin
            mismatch_s  = 1'b0;
            sweep_end_s = 1'b0;
        end
    end

    // Sweep sequencer and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= CNT_ZERO;
            stop_r       <= 1'b0;
            x_r          <= X_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            err_cnt_r    <= ERR_ZERO;
            first_x_r    <= X_ZERO;
            first_a_r    <= Y_ZERO;
            first_b_r    <= Y_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_r      <= ST_DRIVE;
                        settle_cnt_r <= CNT_ZERO;
                        stop_r       <= i_stop_on_err;
                        x_r          <= X_ZERO;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                        err_cnt_r    <= ERR_ZERO;
                        first_x_r    <= X_ZERO;
                        first_a_r    <= Y_ZERO;
                        first_b_r    <= Y_ZERO;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        err_cnt_r <= err_cnt_r + ERR_ONE;
                        error_r   <= 1'b1;
                        // error_r still reflects earlier vectors only
                        if (!error_r) begin
                            first_x_r <= x_r;
                            first_a_r <= i_y_a;
                            first_b_r <= i_y_b;
                        end else begin
                            first_x_r <= first_x_r;
                        end
                    end else begin
                        err_cnt_r <= err_cnt_r;
                    end
                    if (sweep_end_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r      <= ST_DRIVE;
                        settle_cnt_r <= CNT_ZERO;
                        x_r          <= x_r + X_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_x       = x_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_error   = error_r;
    assign o_err_cnt = err_cnt_r;
    assign o_first_x = first_x_r;
    assign o_first_a = first_a_r;
    assign o_first_b = first_b_r;

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Scoreboard bench: implementation A is a random lookup table, B is A with
// injected XOR faults; expected sweep results come from the fault list.
module tb_equiv_sweep_checker;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 5;
    localparam int SETTLE = 1;
    localparam int NVEC   = 1 << IN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_stop_on_err = 1'b0;
    logic [OUT_W-1:0] y_a, y_b;
    logic [IN_W-1:0]  o_x;
    logic             o_busy, o_done, o_error;
    logic [IN_W:0]    o_err_cnt;
    logic [IN_W-1:0]  o_first_x;
    logic [OUT_W-1:0] o_first_a, o_first_b;

    logic [OUT_W-1:0] ya_tab [NVEC];
    logic [OUT_W-1:0] mask   [NVEC];

    typedef struct {
        int cnt;
        int first_x;
        int first_a;
        int first_b;
        int last_x;
        int err;
        int busy;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int fails  = 0;

    equiv_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop_on_err(i_stop_on_err),
        .i_y_a(y_a), .i_y_b(y_b), .o_x(o_x), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_err_cnt(o_err_cnt), .o_first_x(o_first_x),
        .o_first_a(o_first_a), .o_first_b(o_first_b)
    );

    always #5 clk = ~clk;

    assign y_a = ya_tab[o_x];
    assign y_b = ya_tab[o_x] ^ mask[o_x];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: list the faulty vectors, then derive what the sweep must report
    function automatic exp_t build_exp(input bit stop);
        exp_t e;
        int bad[$];
        for (int x = 0; x < NVEC; x++)
            if (mask[x] != 0) bad.push_back(x);
        e.first_x = 0; e.first_a = 0; e.first_b = 0;
        if (bad.size() == 0) begin
            e.cnt = 0; e.err = 0; e.last_x = NVEC - 1;
            e.busy = NVEC * (SETTLE + 1);
        end else begin
            e.err = 1;
            e.first_x = bad[0];
            e.first_a = int'(ya_tab[bad[0]]);
            e.first_b = int'(ya_tab[bad[0]] ^ mask[bad[0]]);
            if (stop) begin
                e.cnt = 1; e.last_x = bad[0];
                e.busy = (bad[0] + 1) * (SETTLE + 1);
            end else begin
                e.cnt = bad.size(); e.last_x = NVEC - 1;
                e.busy = NVEC * (SETTLE + 1);
            end
        end
        return e;
    endfunction

    // Monitor: on each rising o_done, pop the expected result and compare
    initial begin : monitor
        int   busy_cnt = 0;
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_unexpected_done: got done with empty queue");
                end else begin
                    e = sb_q.pop_front();
                    check("err_cnt",     int'(o_err_cnt), e.cnt);
                    check("error",       int'(o_error),   e.err);
                    check("first_x",     int'(o_first_x), e.first_x);
                    check("first_a",     int'(o_first_a), e.first_a);
                    check("first_b",     int'(o_first_b), e.first_b);
                    check("final_x",     int'(o_x),       e.last_x);
                    check("busy_cycles", busy_cnt,        e.busy);
                    check("busy_at_done", int'(o_busy),   0);
                end
                busy_cnt = 0;
            end else if (!o_busy && !o_done) begin
                busy_cnt = 0;
            end
            if (o_busy) busy_cnt++;
            done_prev = o_done;
        end
    end

    task automatic set_tables(input int nfaults, input int f0, input int f1, input int f2);
        for (int x = 0; x < NVEC; x++) begin
            ya_tab[x] = OUT_W'($urandom);
            mask[x]   = '0;
        end
        if (nfaults > 0) mask[f0] = OUT_W'($urandom_range(1, 31));
        if (nfaults > 1) mask[f1] = OUT_W'($urandom_range(1, 31));
        if (nfaults > 2) mask[f2] = OUT_W'($urandom_range(1, 31));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles", n);
        end
    endtask

    task automatic run_sweep(input bit stop, input bit disturb);
        exp_t e;
        e = build_exp(stop);
        sb_q.push_back(e);
        i_stop_on_err = stop;
        pulse_start();
        if (disturb) begin
            repeat (100) @(posedge clk);
            #1 i_start = 1'b1; i_stop_on_err = ~stop;
            @(posedge clk); #1 i_start = 1'b0;
        end
        wait_done();
        repeat (3) @(negedge clk);
        check("hold_done",    int'(o_done),    1);
        check("hold_x",       int'(o_x),       e.last_x);
        check("hold_err_cnt", int'(o_err_cnt), e.cnt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"},       int'(o_x),       0);
        check({tag, "_busy"},    int'(o_busy),    0);
        check({tag, "_done"},    int'(o_done),    0);
        check({tag, "_error"},   int'(o_error),   0);
        check({tag, "_err_cnt"}, int'(o_err_cnt), 0);
        check({tag, "_first_x"}, int'(o_first_x), 0);
        check({tag, "_first_a"}, int'(o_first_a), 0);
        check({tag, "_first_b"}, int'(o_first_b), 0);
    endtask

    initial begin : stimulus
        exp_t dropped;
        set_tables(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        // clean sweep
        set_tables(0, 0, 0, 0);
        run_sweep(1'b0, 1'b0);
        // single fault, stop on first error
        set_tables(1, 8'h5A, 0, 0);
        run_sweep(1'b1, 1'b0);
        // three faults at the sweep extremes, full sweep
        set_tables(3, 8'h00, 8'h80, 8'hFF);
        run_sweep(1'b0, 1'b0);
        // restart from DONE with the same tables: results must reproduce
        sb_q.push_back(build_exp(1'b0));
        i_stop_on_err = 1'b0;
        pulse_start();
        @(negedge clk);
        check("restart_done_low", int'(o_done),    0);
        check("restart_busy",     int'(o_busy),    1);
        check("restart_err_cnt",  int'(o_err_cnt), 0);
        check("restart_x",        int'(o_x),       0);
        wait_done();
        repeat (2) @(negedge clk);

        // start pulse and stop toggle mid-sweep are ignored
        set_tables(0, 0, 0, 0);
        run_sweep(1'b0, 1'b1);
        set_tables(3, 8'h00, 8'h80, 8'hFF);
        run_sweep(1'b0, 1'b1);

        // reset mid-sweep aborts and clears everything
        set_tables(0, 0, 0, 0);
        sb_q.push_back(build_exp(1'b0));
        pulse_start();
        repeat (200) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_all_zero("midrst");
        dropped = sb_q.pop_back();
        run_sweep(1'b0, 1'b0);

        // randomised fault sets
        for (int k = 0; k < 4; k++) begin
            set_tables($urandom_range(0, 3), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 255));
            run_sweep(1'($urandom_range(0, 1)), 1'b0);
        end

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
